// File: rtl/regbank16_wr.sv
// Sixteen-entry write-side register bank with byte enables and a one-entry-per-cycle
// bulk-clear engine that shares the single write port.
module regbank16_wr #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_sel,
    input  logic [1:0]       wr_be,
    input  logic [width-1:0] wr_data,
    input  logic             clear_req,
    output logic             busy,
    output logic [15:0]      valid_map,
    output logic [width-1:0] a,
    output logic [width-1:0] b,
    output logic [width-1:0] c,
    output logic [width-1:0] d,
    output logic [width-1:0] e,
    output logic [width-1:0] f,
    output logic [width-1:0] g,
    output logic [width-1:0] h,
    output logic [width-1:0] i,
    output logic [width-1:0] j,
    output logic [width-1:0] k,
    output logic [width-1:0] l,
    output logic [width-1:0] m,
    output logic [width-1:0] n,
    output logic [width-1:0] o,
    output logic [width-1:0] p
);

    localparam int unsigned half    = width / 2;
    localparam int unsigned entries = 16;
    localparam logic [3:0]  last    = 4'd15;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       clr_cnt;
    logic [3:0]       clr_cnt_next;
    logic [width-1:0] mem [entries];
    logic [width-1:0] merged;
    logic             wr_fire;

    // Next-state and counter logic for the bulk-clear sequencer
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = 4'd0;
                end
            end
            CLEAR: begin
                if (clr_cnt == last) begin
                    state_next   = IDLE;
                    clr_cnt_next = 4'd0;
                end else begin
                    clr_cnt_next = clr_cnt + 4'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = 4'd0;
            end
        endcase
    end

    assign wr_ready = ~rst & (state == IDLE);
    assign busy     = (state == CLEAR);
    assign wr_fire  = wr_valid & wr_ready;

    // Byte-lane merge of incoming data with the currently stored word
    always_comb begin
        merged = mem[wr_sel];
        if (wr_be[0]) begin
            merged[half-1:0] = wr_data[half-1:0];
        end
        if (wr_be[1]) begin
            merged[width-1:half] = wr_data[width-1:half];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Storage: clear engine owns the port while busy, otherwise accepted writes land
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int idx = 0; idx < int'(entries); idx++) begin
                mem[idx] <= '0;
            end
            valid_map <= 16'h0000;
        end else if (state == CLEAR) begin
            mem[clr_cnt]       <= '0;
            valid_map[clr_cnt] <= 1'b0;
        end else if (wr_fire) begin
            mem[wr_sel] <= merged;
            if (wr_be != 2'b00) begin
                valid_map[wr_sel] <= 1'b1;
            end
        end
    end

    assign a = mem[0];
    assign b = mem[1];
    assign c = mem[2];
    assign d = mem[3];
    assign e = mem[4];
    assign f = mem[5];
    assign g = mem[6];
    assign h = mem[7];
    assign i = mem[8];
    assign j = mem[9];
    assign k = mem[10];
    assign l = mem[11];
    assign m = mem[12];
    assign n = mem[13];
    assign o = mem[14];
    assign p = mem[15];

endmodule

// File: tb/tb_regbank16_wr.sv
// Self-checking bench for regbank16_wr: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the bank.
module tb_regbank16_wr;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_sel;
    logic [1:0]   wr_be;
    logic [W-1:0] wr_data;
    logic         clear_req;
    logic         busy;
    logic [15:0]  valid_map;
    logic [W-1:0] a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p;
    logic [W-1:0] dut_ent [16];

    int passed = 0;
    int total  = 0;

    regbank16_wr #(.width(W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_be(wr_be),
        .wr_data(wr_data), .clear_req(clear_req), .busy(busy), .valid_map(valid_map),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .i(i), .j(j), .k(k), .l(l), .m(m), .n(n), .o(o), .p(p)
    );

    always #5 clk = ~clk;

    assign dut_ent = '{a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p};

    // Reference model: contents, valid bits, and remaining clear cycles
    logic [W-1:0] exp_ent [16];
    logic [15:0]  exp_vmap;
    int           clear_left;
    bit           model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int x = 0; x < 16; x++) exp_ent[x] = '0;
            exp_vmap   = '0;
            clear_left = 0;
            model_live = 1;
        end else if (clear_left > 0) begin
            exp_ent[16 - clear_left]  = '0;
            exp_vmap[16 - clear_left] = 1'b0;
            clear_left--;
        end else begin
            if (wr_valid) begin
                if (wr_be[0]) exp_ent[wr_sel][7:0]  = wr_data[7:0];
                if (wr_be[1]) exp_ent[wr_sel][15:8] = wr_data[15:8];
                if (wr_be != 2'b00) exp_vmap[wr_sel] = 1'b1;
            end
            if (clear_req) clear_left = 16;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            check("wr_ready", 32'(wr_ready), 32'(!rst && clear_left == 0));
            check("busy", 32'(busy), 32'(clear_left > 0));
            check("valid_map", 32'(valid_map), 32'(exp_vmap));
            for (int x = 0; x < 16; x++)
                check($sformatf("entry%0d", x), 32'(dut_ent[x]), 32'(exp_ent[x]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        wr_be     = 2'b00;
        wr_sel    = 4'd0;
        wr_data   = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int accepted;
    int busy_cycles;
    int wait_cycles;
    int h_cycles;

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        check("ready_in_reset", 32'(wr_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("reset_vmap", 32'(valid_map), 32'h0);
        check("reset_ready", 32'(wr_ready), 32'd1);

        // Single full write
        wr_valid = 1'b1; wr_sel = 4'd3; wr_be = 2'b11; wr_data = 16'hBEEF;
        step();
        wr_valid = 1'b0;
        check("first_d", 32'(d), 32'hBEEF);
        check("first_vmap", 32'(valid_map), 32'h0008);
        check("first_c", 32'(c), 32'h0);

        // Byte merges on entry 3
        wr_valid = 1'b1; wr_be = 2'b01; wr_data = 16'h1234;
        step();
        check("merge_lo", 32'(d), 32'hBE34);
        wr_be = 2'b10; wr_data = 16'h5600;
        step();
        check("merge_hi", 32'(d), 32'h5634);
        wr_be = 2'b00; wr_data = 16'hFFFF;
        step();
        wr_valid = 1'b0;
        check("be00_d", 32'(d), 32'h5634);
        check("be00_vmap", 32'(valid_map), 32'h0008);

        // Fill all entries back to back
        accepted = 0;
        for (int x = 0; x < 16; x++) begin
            wr_valid = 1'b1; wr_sel = 4'(x); wr_be = 2'b11; wr_data = 16'h1000 + 16'(x);
            if (wr_ready) accepted++;
            step();
        end
        wr_valid = 1'b0;
        check("fill_accepted", 32'(accepted), 32'd16);
        check("fill_a", 32'(a), 32'h1000);
        check("fill_p", 32'(p), 32'h100F);
        check("fill_vmap", 32'(valid_map), 32'hFFFF);

        // Bulk clear with a held write and a redundant clear_req mid-way
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wr_valid = 1'b1; wr_sel = 4'd5; wr_be = 2'b11; wr_data = 16'hAAAA;
        busy_cycles = 0;
        wait_cycles = 0;
        for (int x = 0; x < 40; x++) begin
            if (busy) busy_cycles++;
            if (wr_ready) break;
            clear_req = (x == 5);
            step();
            clear_req = 1'b0;
            wait_cycles++;
        end
        check("clear_busy_len", 32'(busy_cycles), 32'd16);
        check("clear_wait", 32'(wait_cycles), 32'd16);
        step();
        wr_valid = 1'b0;
        check("post_clear_f", 32'(f), 32'hAAAA);
        check("post_clear_b", 32'(b), 32'h0);
        check("post_clear_vmap", 32'(valid_map), 32'h0020);
        check("post_clear_busy", 32'(busy), 32'd0);

        // Clear request coincident with a write to entry 7
        wr_valid = 1'b1; wr_sel = 4'd7; wr_be = 2'b11; wr_data = 16'h7777; clear_req = 1'b1;
        step();
        idle_inputs();
        h_cycles = 0;
        for (int x = 0; x < 20; x++) begin
            if (h == 16'h7777) h_cycles++;
            step();
        end
        check("h_live_cycles", 32'(h_cycles), 32'd8);
        check("coinc_vmap", 32'(valid_map), 32'h0);
        check("coinc_h", 32'(h), 32'h0);

        // Reset in the middle of a clear
        for (int x = 0; x < 16; x++) begin
            wr_valid = 1'b1; wr_sel = 4'(x); wr_be = 2'b11; wr_data = 16'(32'h5A00 + x);
            step();
        end
        idle_inputs();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(wr_ready), 32'd1);
        check("rst_mid_vmap", 32'(valid_map), 32'h0);
        check("rst_mid_p", 32'(p), 32'h0);

        // Random traffic
        for (int x = 0; x < 600; x++) begin
            rst       = ($urandom_range(0, 99) == 0);
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_sel    = 4'($urandom_range(0, 15));
            wr_be     = 2'($urandom_range(0, 3));
            wr_data   = 16'($urandom);
            clear_req = ($urandom_range(0, 24) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (20) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
